leds_pattern_gen: RTL and testbench

Parametrised LED pattern generator driving a bank of `NUM_LEDS` board LEDs from a programmable prescaler. It is the generalised successor of the fixed 4-LED swinger: it has run-time selectable mode (off / bounce / rotate / blink), a runtime prescale value, a pause input and a step strobe. It sits at the top level next to the board pinout, runs in the system clock domain, and is controlled by static straps or a register block.

---
 rtl/leds_pkg.sv | 16 +
 rtl/leds_prescaler.sv | 47 ++++
 rtl/leds_pattern_gen.sv | 131 +++++++++++++
 tb/tb_leds_pattern_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/leds_pkg.sv
// Shared types for the LED pattern generator: pattern modes and bounce direction.
package leds_pkg;

  typedef enum logic [1:0] {
    LEDS_OFF    = 2'd0,
    LEDS_BOUNCE = 2'd1,
    LEDS_ROTATE = 2'd2,
    LEDS_BLINK  = 2'd3
  } leds_mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } leds_dir_t;

endpackage

// File: rtl/leds_prescaler.sv
// Programmable prescaler: asserts TICK once every PRESCALE+1 enabled cycles.
// The >= compare lets a lowered PRESCALE take effect at once without overrun.
module leds_prescaler
  import leds_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ENABLE,
  input  logic                      CLEAR,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TICK
);

  localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

  // Next count and tick: clear wins, then count enabled cycles up to PRESCALE.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    TICK  = 1'b0;
    if (CLEAR) begin
      cnt_d = '0;
    end else if (ENABLE) begin
      if (cnt_q >= PRESCALE) begin
        TICK  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Count register with synchronous reset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/leds_pattern_gen.sv
// LED pattern generator: OFF / BOUNCE / ROTATE / BLINK patterns advanced by a
// programmable prescaler, with registered DATA and a one-cycle STEP pulse.
module leds_pattern_gen
  import leds_pkg::*;
#(
  parameter int NUM_LEDS       = 8,
  parameter int WIN            = 2,
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ENABLE,
  input  logic [1:0]                MODE,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic [NUM_LEDS-1:0]       DATA,
  output logic                      STEP
);

  // Parameter legality is checked while elaborating.
  if (NUM_LEDS < 2) begin : g_bad_num_leds
    $error("leds_pattern_gen: NUM_LEDS must be at least 2");
  end
  if ((WIN < 1) || (WIN > NUM_LEDS)) begin : g_bad_win
    $error("leds_pattern_gen: WIN must satisfy 1 <= WIN <= NUM_LEDS");
  end

  // WIN ones packed at the LSB end, built bit by bit so WIN == NUM_LEDS is legal.
  function automatic logic [NUM_LEDS-1:0] win_init();
    logic [NUM_LEDS-1:0] v;
    v = '0;
    for (int i = 0; i < WIN; i++) begin
      v[i] = 1'b1;
    end
    return v;
  endfunction

  localparam logic [NUM_LEDS-1:0] WIN_INIT = win_init();
  localparam logic [NUM_LEDS-1:0] ALL_ONES = '1;

  leds_mode_t              mode_in;
  leds_mode_t              mode_q, mode_d;
  leds_dir_t               dir_q, dir_d;
  leds_dir_t               bounce_dir;
  logic [NUM_LEDS-1:0]     data_q, data_d;
  logic [NUM_LEDS-1:0]     bounce_data;
  logic                    step_q, step_d;
  logic                    mode_change;
  logic                    presc_clear;
  logic                    tick;

  assign mode_in     = leds_mode_t'(MODE);
  assign mode_change = (mode_in != mode_q);
  // The counter restarts on any load and idles at zero while OFF.
  assign presc_clear = mode_change || (mode_q == LEDS_OFF);

  leds_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .CLK     (CLK),
    .RST     (RST),
    .ENABLE  (ENABLE),
    .CLEAR   (presc_clear),
    .PRESCALE(PRESCALE),
    .TICK    (tick)
  );

  // Bounce move: shift one place, then turn around when the window hits an end.
  always_comb begin
    bounce_data = data_q;
    bounce_dir  = dir_q;
    // A full-width window has nowhere to move, so it simply stays lit.
    if (WIN < NUM_LEDS) begin
      bounce_data = (dir_q == DIR_LEFT) ? (data_q << 1) : (data_q >> 1);
      if (bounce_data[NUM_LEDS-1]) begin
        bounce_dir = DIR_RIGHT;
      end else if (bounce_data[0]) begin
        bounce_dir = DIR_LEFT;
      end
    end
  end

  // Next pattern state: a mode change loads the new initial pattern and
  // swallows any coincident tick; otherwise a tick advances the pattern.
  always_comb begin
    mode_d = mode_q;
    data_d = data_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (mode_change) begin
      mode_d = mode_in;
      dir_d  = DIR_LEFT;
      unique case (mode_in)
        LEDS_OFF:    data_d = '0;
        LEDS_BOUNCE: data_d = WIN_INIT;
        LEDS_ROTATE: data_d = WIN_INIT;
        LEDS_BLINK:  data_d = ALL_ONES;
        default:     data_d = '0;
      endcase
    end else if (tick) begin
      step_d = 1'b1;
      unique case (mode_q)
        LEDS_BOUNCE: begin
          data_d = bounce_data;
          dir_d  = bounce_dir;
        end
        LEDS_ROTATE: data_d = {data_q[NUM_LEDS-2:0], data_q[NUM_LEDS-1]};
        LEDS_BLINK:  data_d = ~data_q;
        default:     data_d = data_q;
      endcase
    end
  end

  // Pattern, mode, direction and step registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q <= LEDS_OFF;
      dir_q  <= DIR_LEFT;
      data_q <= '0;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      data_q <= data_d;
      step_q <= step_d;
    end
  end

  assign DATA = data_q;
  assign STEP = step_q;

endmodule

// File: tb/tb_leds_pattern_gen.sv
// Scoreboard bench for leds_pattern_gen: two instances (WIN=2 and WIN=4, both
// 4 LEDs) share the stimulus; a position/phase reference model predicts each
// cycle's DATA/STEP and a monitor compares every cycle.
module tb_leds_pattern_gen;

  localparam int N  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic [PW-1:0] presc;
  logic [N-1:0]  data_a, data_b;
  logic          step_a, step_b;

  always #5 clk = ~clk;

  leds_pattern_gen #(.NUM_LEDS(N), .WIN(2), .PRESCALE_WIDTH(PW)) u_dut_a (
    .CLK(clk), .RST(rst), .ENABLE(en), .MODE(mode), .PRESCALE(presc),
    .DATA(data_a), .STEP(step_a)
  );

  leds_pattern_gen #(.NUM_LEDS(N), .WIN(N), .PRESCALE_WIDTH(PW)) u_dut_b (
    .CLK(clk), .RST(rst), .ENABLE(en), .MODE(mode), .PRESCALE(presc),
    .DATA(data_b), .STEP(step_b)
  );

  // Abstract model state: window position/direction for bounce, rotation or
  // blink phase otherwise; the LED word is derived from these.
  typedef struct {
    int           mode;
    int           cnt;
    int           pos;
    int           dir;
    int           phase;
    logic [N-1:0] data;
    logic         step;
  } model_t;

  typedef struct {
    logic [N-1:0] da;
    logic         sa;
    logic [N-1:0] db;
    logic         sb;
  } exp_t;

  model_t ma, mb;
  exp_t   exp_q[$];
  exp_t   mon_e;
  int     n_tests = 0;
  int     n_fail  = 0;

  function automatic logic [N-1:0] pattern(int m, int pos, int phase, int win);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) begin
      case (m)
        1:       p[i] = (i >= pos) && (i < pos + win);
        2:       p[i] = (((i - phase + N) % N) < win);
        3:       p[i] = (phase == 0);
        default: p[i] = 1'b0;
      endcase
    end
    return p;
  endfunction

  function automatic model_t model_next(model_t s, logic r, logic e, int m, int pr, int win);
    model_t n;
    n = s;
    n.step = 1'b0;
    if (r) begin
      n.mode = 0; n.cnt = 0; n.pos = 0; n.dir = 1; n.phase = 0; n.data = '0;
    end else if (m != s.mode) begin
      n.mode = m; n.cnt = 0; n.pos = 0; n.dir = 1; n.phase = 0;
      n.data = pattern(m, 0, 0, win);
    end else if (s.mode != 0 && e) begin
      if (s.cnt >= pr) begin
        n.cnt  = 0;
        n.step = 1'b1;
        case (s.mode)
          1: if (win < N) begin
               n.pos = s.pos + s.dir;
               if (n.pos == N - win) n.dir = -1;
               else if (n.pos == 0)  n.dir = 1;
             end
          2:       n.phase = (s.phase + 1) % N;
          default: n.phase = 1 - s.phase;
        endcase
        n.data = pattern(n.mode, n.pos, n.phase, win);
      end else begin
        n.cnt = s.cnt + 1;
      end
    end
    return n;
  endfunction

  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Predict the effect of the inputs now applied, then let one edge pass.
  task automatic cycle();
    exp_t e;
    ma = model_next(ma, rst, en, int'(mode), int'(presc), 2);
    mb = model_next(mb, rst, en, int'(mode), int'(presc), N);
    e.da = ma.data; e.sa = ma.step; e.db = mb.data; e.sb = mb.step;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: DATA/STEP are valid every cycle; compare just after each edge.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("data_win2", data_a, mon_e.da);
      check("step_win2", {{(N-1){1'b0}}, step_a}, {{(N-1){1'b0}}, mon_e.sa});
      check("data_win4", data_b, mon_e.db);
      check("step_win4", {{(N-1){1'b0}}, step_b}, {{(N-1){1'b0}}, mon_e.sb});
    end
  end

  initial begin
    int guard;
    ma = '{mode: 0, cnt: 0, pos: 0, dir: 1, phase: 0, data: '0, step: 1'b0};
    mb = ma;
    rst = 1'b1; en = 1'b1; mode = 2'd1; presc = 8'd2;
    run(3);

    // Reset release into BOUNCE, then ROTATE.
    rst = 1'b0;
    run(25);
    mode = 2'd2;
    run(16);

    // BLINK every cycle.
    mode = 2'd3; presc = 8'd0;
    run(10);

    // ROTATE pause at 0110 with cnt 1.
    mode = 2'd2; presc = 8'd2;
    guard = 0;
    cycle();
    while (!(ma.data == 4'b0110 && ma.cnt == 1) && guard < 40) begin
      cycle();
      guard++;
    end
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(8);

    // BOUNCE -> BLINK on a tick cycle: tick is dropped.
    mode = 2'd1;
    cycle();
    run(4);
    guard = 0;
    while (ma.cnt < int'(presc) && guard < 20) begin
      cycle();
      guard++;
    end
    mode = 2'd3;
    run(4);

    // PRESCALE 9 -> 1 while cnt is 5.
    mode = 2'd1; presc = 8'd9;
    cycle();
    guard = 0;
    while (ma.cnt != 5 && guard < 20) begin
      cycle();
      guard++;
    end
    presc = 8'd1;
    run(6);

    // Reset mid-BOUNCE, then OFF.
    presc = 8'd2;
    run(4);
    rst = 1'b1;
    cycle();
    rst = 1'b0; mode = 2'd0;
    run(12);

    // Randomised stimulus.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) presc = PW'($urandom_range(0, 4));
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    run(2);

    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
